// File: rtl/dense_layer_pipeline.sv
// dense_layer_pipeline: fully pipelined Q-format dense layer,
// out[j] = ACT(sum_i z[i]*w[i][j] + b[j]) with saturating arithmetic.
//
// Parameters:
//   N_INPUT  inputs per vector (>=1)
//   M_OUTPUT neurons / outputs (>=1)
//   BITSIZE  word width, two's complement
//   FRAC     fractional bits of the Q-format
//   ACT      0 = identity, 1 = ReLU
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   in_valid/ready   input handshake (in_ready = !stall)
//   z                input vector, z[i] at [i*BITSIZE +: BITSIZE]
//   w                weights, w[i][j] at [(j*N_INPUT+i)*BITSIZE +: BITSIZE]
//   b                bias, b[j] at [j*BITSIZE +: BITSIZE]
//   out_valid/ready  output handshake
//   out              result vector, packed like b
//   out_sat          saturation seen while computing this out vector
// Latency is ceil(log2(N_INPUT)) + 2 cycles from input transfer.

module dense_layer_pipeline #(
  parameter int N_INPUT  = 2,
  parameter int M_OUTPUT = 9,
  parameter int BITSIZE  = 16,
  parameter int FRAC     = 8,
  parameter int ACT      = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]            z,
  input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0]   w,
  input  logic [M_OUTPUT*BITSIZE-1:0]           b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]           out,
  output logic                                  out_sat
);

  localparam int B = BITSIZE;
  localparam int D = (N_INPUT > 1) ? $clog2(N_INPUT) : 0;

  typedef logic signed [B-1:0] word_t;

  localparam word_t WMAX = {1'b0, {(B-1){1'b1}}};
  localparam word_t WMIN = {1'b1, {(B-1){1'b0}}};

  localparam logic signed [2*B-1:0] PMAX =
    {{(B+1){1'b0}}, {(B-1){1'b1}}};
  localparam logic signed [2*B-1:0] PMIN =
    {{(B+1){1'b1}}, {(B-1){1'b0}}};

  // Number of live terms entering tree level l.
  function automatic int lvl_cnt(input int l);
    int c;
    c = N_INPUT;
    for (int k = 0; k < l; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Returns {sat, value}; shift is arithmetic, i.e. floor.
  function automatic logic [B:0] mul_sat(
    input word_t a,
    input word_t c
  );
    logic signed [2*B-1:0] p;
    p = (2*B)'(a) * (2*B)'(c);
    p = p >>> FRAC;
    if (p > PMAX)      return {1'b1, WMAX};
    else if (p < PMIN) return {1'b1, WMIN};
    else               return {1'b0, p[B-1:0]};
  endfunction

  // Returns {sat, value}; overflow shows as a sign mismatch
  // between the two top bits of the widened sum.
  function automatic logic [B:0] add_sat(
    input word_t a,
    input word_t c
  );
    logic [B:0] s;
    s = {a[B-1], a} + {c[B-1], c};
    if (s[B] != s[B-1])
      return {1'b1, s[B] ? WMIN : WMAX};
    else
      return {1'b0, s[B-1:0]};
  endfunction

  // Level 0 holds the products, level D the tree root.
  word_t t_q [D+1][M_OUTPUT][N_INPUT];
  word_t t_d [D+1][M_OUTPUT][N_INPUT];
  logic [D:0] v_q, v_d;
  logic [D:0] s_q, s_d;

  word_t o_q [M_OUTPUT];
  word_t o_d [M_OUTPUT];
  logic  ov_q, ov_d;
  logic  os_q, os_d;

  logic       stall;
  logic [B:0] r;
  logic [D:0] ev;
  logic       fin_ev;

  assign stall     = ov_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = ov_q;
  assign out_sat   = os_q;

  for (genvar j = 0; j < M_OUTPUT; j++) begin : g_out
    assign out[j*B +: B] = o_q[j];
  end

  always_comb begin
    t_d    = t_q;
    o_d    = o_q;
    ev     = '0;
    fin_ev = 1'b0;
    r      = '0;
    v_d    = '0;
    s_d    = '0;

    for (int j = 0; j < M_OUTPUT; j++) begin
      for (int i = 0; i < N_INPUT; i++) begin
        r = mul_sat(
          word_t'(z[i*B +: B]),
          word_t'(w[(j*N_INPUT+i)*B +: B]));
        t_d[0][j][i] = r[B-1:0];
        ev[0] = ev[0] | r[B];
      end
    end

    // Pairs (2k, 2k+1); an odd leftover passes through.
    for (int l = 0; l < D; l++) begin
      for (int j = 0; j < M_OUTPUT; j++) begin
        for (int k = 0; k < N_INPUT; k++) begin
          if (2*k+1 < lvl_cnt(l)) begin
            r = add_sat(t_q[l][j][2*k],
                        t_q[l][j][2*k+1]);
            t_d[l+1][j][k] = r[B-1:0];
            ev[l+1] = ev[l+1] | r[B];
          end else if (2*k < lvl_cnt(l)) begin
            t_d[l+1][j][k] = t_q[l][j][2*k];
          end else begin
            t_d[l+1][j][k] = '0;
          end
        end
      end
    end

    // ReLU clamps after bias saturation; the flag survives.
    for (int j = 0; j < M_OUTPUT; j++) begin
      r = add_sat(t_q[D][j][0], word_t'(b[j*B +: B]));
      fin_ev = fin_ev | r[B];
      if (ACT == 1 && r[B-1]) o_d[j] = '0;
      else                    o_d[j] = r[B-1:0];
    end

    // Bubbles carry a cleared sat bit.
    v_d[0] = in_valid;
    s_d[0] = in_valid & ev[0];
    for (int l = 0; l < D; l++) begin
      v_d[l+1] = v_q[l];
      s_d[l+1] = v_q[l] & (s_q[l] | ev[l+1]);
    end

    ov_d = v_q[D];
    os_d = v_q[D] & (s_q[D] | fin_ev);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q  <= '{default: '0};
      v_q  <= '0;
      s_q  <= '0;
      o_q  <= '{default: '0};
      ov_q <= 1'b0;
      os_q <= 1'b0;
    end else if (!stall) begin
      t_q  <= t_d;
      v_q  <= v_d;
      s_q  <= s_d;
      o_q  <= o_d;
      ov_q <= ov_d;
      os_q <= os_d;
    end
  end

endmodule

// File: tb/tb_dense_layer_pipeline.sv
// tb_dense_layer_pipeline: directed checks of dense_layer_pipeline
// (basic, saturation, ReLU, odd tree, backpressure, reset).

module tb_dense_layer_pipeline;

  logic clk = 1'b0;
  logic reset;
  logic vin;
  logic ordy;

  always #5 clk = ~clk;

  // A: N=2 M=9 identity
  logic [31:0]  a_z;
  logic [287:0] a_w;
  logic [143:0] a_b;
  logic [143:0] a_out;
  logic a_ird, a_ov, a_sat;

  // R: N=2 M=9 ReLU
  logic [31:0]  r_z;
  logic [287:0] r_w;
  logic [143:0] r_b;
  logic [143:0] r_out;
  logic r_ird, r_ov, r_sat;

  // O: N=5 M=3 identity
  logic [79:0]  o_z;
  logic [239:0] o_w;
  logic [47:0]  o_b;
  logic [47:0]  o_out;
  logic o_ird, o_ov, o_sat;

  int n_cmp = 0;
  int n_bad = 0;

  int a_lat, r_lat, o_lat;
  logic [143:0] a_cap, r_cap;
  logic [47:0]  o_cap;
  logic a_scap, r_scap, o_scap;

  dense_layer_pipeline #(
    .N_INPUT(2), .M_OUTPUT(9), .BITSIZE(16),
    .FRAC(8), .ACT(0)
  ) u_a (
    .clk(clk), .reset(reset),
    .in_valid(vin), .in_ready(a_ird),
    .z(a_z), .w(a_w), .b(a_b),
    .out_valid(a_ov), .out_ready(ordy),
    .out(a_out), .out_sat(a_sat)
  );

  dense_layer_pipeline #(
    .N_INPUT(2), .M_OUTPUT(9), .BITSIZE(16),
    .FRAC(8), .ACT(1)
  ) u_r (
    .clk(clk), .reset(reset),
    .in_valid(vin), .in_ready(r_ird),
    .z(r_z), .w(r_w), .b(r_b),
    .out_valid(r_ov), .out_ready(ordy),
    .out(r_out), .out_sat(r_sat)
  );

  dense_layer_pipeline #(
    .N_INPUT(5), .M_OUTPUT(3), .BITSIZE(16),
    .FRAC(8), .ACT(0)
  ) u_o (
    .clk(clk), .reset(reset),
    .in_valid(vin), .in_ready(o_ird),
    .z(o_z), .w(o_w), .b(o_b),
    .out_valid(o_ov), .out_ready(ordy),
    .out(o_out), .out_sat(o_sat)
  );

  task automatic check(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One vector into every DUT; records first out_valid
  // cycle (counted from the accepting edge) and the result.
  task automatic one_shot();
    @(negedge clk);
    vin = 1'b1;
    @(posedge clk);
    a_lat = 0; r_lat = 0; o_lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vin = 1'b0;
      if (a_ov && a_lat == 0) begin
        a_lat = c; a_cap = a_out; a_scap = a_sat;
      end
      if (r_ov && r_lat == 0) begin
        r_lat = c; r_cap = r_out; r_scap = r_sat;
      end
      if (o_ov && o_lat == 0) begin
        o_lat = c; o_cap = o_out; o_scap = o_sat;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int tx, rx, stale;
    logic [15:0] e;

    reset = 1'b1;
    vin   = 1'b0;
    ordy  = 1'b0;
    a_z = '0; a_w = '0; a_b = '0;
    r_z = '0; r_w = '0; r_b = '0;
    o_z = '0; o_w = '0; o_b = '0;
    #1;
    check("rst_ov",  256'(a_ov),  256'(0));
    check("rst_out", 256'(a_out), 256'(0));
    check("rst_sat", 256'(a_sat), 256'(0));
    check("rst_ird", 256'(a_ird), 256'(1));

    repeat (2) @(negedge clk);
    reset = 1'b0;
    ordy  = 1'b1;

    // Basic / ReLU negative / odd tree
    a_z = {16'd512, 16'd256};
    a_w = {18{16'd128}};
    a_b = {9{16'd64}};
    r_z = {2{16'd256}};
    r_w = {18{16'hff00}};
    r_b = '0;
    o_z = {5{16'd256}};
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 5; i++)
        o_w[(j*5+i)*16 +: 16] = 16'(256*(i+1));
    o_b = '0;
    one_shot();
    check("basic_lat", 256'(a_lat), 256'(3));
    check("basic_out", 256'(a_cap), 256'({9{16'd448}}));
    check("basic_sat", 256'(a_scap), 256'(0));
    check("relu0_lat", 256'(r_lat), 256'(3));
    check("relu0_out", 256'(r_cap), 256'(0));
    check("relu0_sat", 256'(r_scap), 256'(0));
    check("odd_lat", 256'(o_lat), 256'(5));
    check("odd_out", 256'(o_cap), 256'({3{16'd3840}}));
    check("odd_sat", 256'(o_scap), 256'(0));

    // Positive saturation / ReLU with bias
    a_z = {2{16'd32512}};
    a_w = {18{16'd512}};
    a_b = '0;
    r_b = {9{16'd1024}};
    one_shot();
    check("satp_out", 256'(a_cap), 256'({9{16'h7fff}}));
    check("satp_sat", 256'(a_scap), 256'(1));
    check("relu1_out", 256'(r_cap), 256'({9{16'd512}}));
    check("relu1_sat", 256'(r_scap), 256'(0));

    // Negative saturation
    a_w = {18{16'hfe00}};
    one_shot();
    check("satn_lat", 256'(a_lat), 256'(3));
    check("satn_out", 256'(a_cap), 256'({9{16'h8000}}));
    check("satn_sat", 256'(a_scap), 256'(1));

    // Backpressure: 8 vectors, out_ready low 5 cycles
    a_w = {18{16'd128}};
    a_b = {9{16'd64}};
    tx = 0; rx = 0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      @(negedge clk);
      ordy = !(c >= 6 && c <= 10);
      if (tx < 8) begin
        vin = 1'b1;
        a_z = {16'd256, 16'(256*tx)};
      end else begin
        vin = 1'b0;
      end
      #1;
      if (a_ov) begin
        e = 16'(128*rx + 192);
        check("bp_data", 256'(a_out), 256'({9{e}}));
        check("bp_sat", 256'(a_sat), 256'(0));
        if (!ordy) check("bp_ird", 256'(a_ird), 256'(0));
      end
      if (a_ov && ordy) rx++;
      if (vin && a_ird) tx++;
    end
    check("bp_rx", 256'(rx), 256'(8));
    check("bp_tx", 256'(tx), 256'(8));
    @(negedge clk);
    vin  = 1'b0;
    ordy = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_drain", 256'(a_ov), 256'(0));

    // Reset with 3 saturating vectors in flight
    a_z = {2{16'd32512}};
    a_w = {18{16'd512}};
    a_b = '0;
    @(negedge clk);
    vin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    check("mrst_pre_ov", 256'(a_ov), 256'(1));
    check("mrst_pre_sat", 256'(a_sat), 256'(1));
    reset = 1'b1;
    #1;
    check("mrst_ov", 256'(a_ov), 256'(0));
    check("mrst_sat", 256'(a_sat), 256'(0));
    check("mrst_out", 256'(a_out), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ov) stale++;
    end
    check("mrst_stale", 256'(stale), 256'(0));
    a_z = {16'd512, 16'd256};
    a_w = {18{16'd128}};
    a_b = {9{16'd64}};
    one_shot();
    check("mrst_lat", 256'(a_lat), 256'(3));
    check("mrst_out2", 256'(a_cap), 256'({9{16'd448}}));
    check("mrst_sat2", 256'(a_scap), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
